// File: rtl/rc_channel_scheduler.sv
// rtl/rc_channel_scheduler.sv - round-robin RC PWM pulse-width scheduler
// One measurement engine shared across the PWM inputs, with hysteresis classification.
module rc_channel_scheduler #(
  parameter int NUM_CHANNELS       = 4,
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1800,
  parameter int LOW_COUNTER_VALUE  = 1200,
  parameter int TIMEOUT_VALUE      = 25000,
  parameter int WIDTH_BITS         = 11
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [NUM_CHANNELS-1:0] channel_enable_i,
  input  logic [NUM_CHANNELS-1:0] pwm_i,
  output logic [NUM_CHANNELS-1:0] channel_state_o,
  output logic [NUM_CHANNELS-1:0] channel_valid_o,
  output logic [WIDTH_BITS-1:0]   width_o,
  output logic [1:0]              width_channel_o,
  output logic                    width_valid_o,
  output logic                    busy_o
);

  localparam logic [14:0]           TIMEOUT_LIM = 15'(TIMEOUT_VALUE);
  localparam logic [WIDTH_BITS-1:0] ABORT_LIM   = WIDTH_BITS'(MAX_COUNTER_VALUE + 1);
  localparam logic [WIDTH_BITS-1:0] HIGH_LIM    = WIDTH_BITS'(HIGH_COUNTER_VALUE);
  localparam logic [WIDTH_BITS-1:0] LOW_LIM     = WIDTH_BITS'(LOW_COUNTER_VALUE);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    EVAL,
    ADVANCE
  } state_t;

  state_t                  state, state_next;
  logic [NUM_CHANNELS-1:0] sync_q1, sync_q2;
  logic [1:0]              ptr, ptr_next;
  logic [WIDTH_BITS-1:0]   width_cnt, width_cnt_next;
  logic [14:0]             timeout_cnt, timeout_cnt_next;
  logic                    meas_done, meas_fail;
  logic                    s_cur;
  logic [NUM_CHANNELS-1:0] valid_next, chan_state_next;

  // First enabled index strictly after 'from', wrapping; 'from' itself is checked last.
  function automatic logic [1:0] next_enabled(input logic [1:0] from,
                                               input logic [NUM_CHANNELS-1:0] mask);
    logic [1:0] result;
    logic [1:0] idx;
    result = from;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      idx = from + 2'(i);
      if (mask[idx]) result = idx;
    end
    return result;
  endfunction

  assign s_cur  = sync_q2[ptr];
  assign busy_o = (state != IDLE);

  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    width_cnt_next   = width_cnt;
    timeout_cnt_next = timeout_cnt;
    meas_done        = 1'b0;
    meas_fail        = 1'b0;
    if (!enable_i) begin
      state_next       = IDLE;
      width_cnt_next   = '0;
      timeout_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (|channel_enable_i) begin
            ptr_next   = next_enabled(2'd3, channel_enable_i);
            state_next = WAIT_LOW;
          end
        end
        WAIT_LOW, WAIT_RISE: begin
          if (timeout_cnt >= TIMEOUT_LIM) begin
            meas_fail  = 1'b1;
            state_next = ADVANCE;
          end else begin
            timeout_cnt_next = timeout_cnt + 15'd1;
            if (state == WAIT_LOW && !s_cur) begin
              state_next = WAIT_RISE;
            end else if (state == WAIT_RISE && s_cur) begin
              width_cnt_next = WIDTH_BITS'(1);
              state_next     = MEASURE;
            end
          end
        end
        MEASURE: begin
          if (width_cnt >= ABORT_LIM) begin
            meas_fail  = 1'b1;
            state_next = ADVANCE;
          end else if (!s_cur) begin
            state_next = EVAL;
          end else if (width_cnt != '1) begin
            width_cnt_next = width_cnt + WIDTH_BITS'(1);
          end
        end
        EVAL: begin
          meas_done  = 1'b1;
          state_next = ADVANCE;
        end
        ADVANCE: begin
          width_cnt_next   = '0;
          timeout_cnt_next = '0;
          if (|channel_enable_i) begin
            ptr_next   = next_enabled(ptr, channel_enable_i);
            state_next = WAIT_LOW;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Widths inside the LOW..HIGH band keep the previous state (hysteresis).
  always_comb begin
    valid_next      = channel_valid_o;
    chan_state_next = channel_state_o;
    if (meas_done) begin
      valid_next[ptr] = 1'b1;
      if (width_cnt >= HIGH_LIM) begin
        chan_state_next[ptr] = 1'b1;
      end else if (width_cnt <= LOW_LIM) begin
        chan_state_next[ptr] = 1'b0;
      end
    end
    if (meas_fail) valid_next[ptr] = 1'b0;
    valid_next = valid_next & channel_enable_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q1         <= '0;
      sync_q2         <= '0;
      state           <= IDLE;
      ptr             <= '0;
      width_cnt       <= '0;
      timeout_cnt     <= '0;
      channel_state_o <= '0;
      channel_valid_o <= '0;
      width_o         <= '0;
      width_channel_o <= '0;
      width_valid_o   <= 1'b0;
    end else begin
      sync_q1         <= pwm_i;
      sync_q2         <= sync_q1;
      state           <= state_next;
      ptr             <= ptr_next;
      width_cnt       <= width_cnt_next;
      timeout_cnt     <= timeout_cnt_next;
      channel_state_o <= chan_state_next;
      channel_valid_o <= valid_next;
      width_valid_o   <= meas_done;
      if (meas_done) begin
        width_o         <= width_cnt;
        width_channel_o <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// tb/tb_rc_channel_scheduler.sv - directed self-checking bench for rc_channel_scheduler
module tb_rc_channel_scheduler;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [3:0]  channel_enable_i;
  logic [3:0]  pwm_i;
  logic [3:0]  channel_state_o;
  logic [3:0]  channel_valid_o;
  logic [10:0] width_o;
  logic [1:0]  width_channel_o;
  logic        width_valid_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Per-channel periodic pulse generator; a new width takes effect at the next period start.
  int unsigned gp[4]   = '{2500, 2500, 2500, 2500};
  int unsigned gw[4]   = '{0, 0, 0, 0};
  int unsigned gcur[4] = '{0, 0, 0, 0};
  int unsigned goff[4] = '{0, 0, 0, 0};
  bit [3:0]    gen_en  = 4'b0000;
  int unsigned phase   = 0;

  rc_channel_scheduler dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .channel_enable_i (channel_enable_i),
    .pwm_i            (pwm_i),
    .channel_state_o  (channel_state_o),
    .channel_valid_o  (channel_valid_o),
    .width_o          (width_o),
    .width_channel_o  (width_channel_o),
    .width_valid_o    (width_valid_o),
    .busy_o           (busy_o)
  );

  initial forever #5 clock_i = ~clock_i;

  initial begin
    pwm_i = 4'b0000;
    forever begin
      @(negedge clock_i);
      phase++;
      for (int c = 0; c < 4; c++) begin
        int unsigned pos;
        pos = (phase + goff[c]) % gp[c];
        if (pos == 0) gcur[c] = gw[c];
        pwm_i[c] = gen_en[c] && (pos < gcur[c]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock_i);
      #1;
    end
  endtask

  task automatic wait_strobe(input int limit, output int ch, output int w, output int cyc);
    ch  = -1;
    w   = -1;
    cyc = 0;
    for (int i = 0; i < limit && ch < 0; i++) begin
      @(negedge clock_i);
      #1;
      cyc++;
      if (width_valid_o) begin
        ch = int'(width_channel_o);
        w  = int'(width_o);
      end
    end
  endtask

  task automatic wait_level(input int c, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick(1);
      if (pwm_i[c] == lvl) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_i          = 1'b1;
    enable_i         = 1'b0;
    channel_enable_i = 4'b0000;
    tick(3);
    checks++;
    if (channel_state_o !== 4'b0000 || channel_valid_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: state=%b valid=%b, expected 0000 0000", channel_state_o, channel_valid_o);
    end
    checks++;
    if (width_o !== 11'd0 || width_channel_o !== 2'd0 || width_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: width=%0d ch=%0d strobe=%b busy=%b, expected all 0",
               width_o, width_channel_o, width_valid_o, busy_o);
    end
    reset_i = 1'b0;
    tick(3);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_when_disabled: busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_sequence;
    int wl[6]     = '{1900, 1500, 1100, 1500, 1800, 1200};
    bit exp_st[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int ch, w, cyc;
    channel_enable_i = 4'b0001;
    gp[0] = 2500; goff[0] = 0; gw[0] = 1900;
    gen_en = 4'b0001;
    tick(5);
    enable_i = 1'b1;
    tick(1);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_enable: busy=%b, expected 1", busy_o);
    end
    for (int k = 0; k < 6; k++) begin
      wait_strobe(6000, ch, w, cyc);
      checks++;
      if (ch != 0 || w != wl[k]) begin
        errors++;
        $display("FAIL seq_strobe_%0d: ch=%0d width=%0d, expected ch=0 width=%0d", k, ch, w, wl[k]);
      end
      checks++;
      if (channel_state_o[0] !== exp_st[k] || channel_valid_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL seq_state_%0d: state0=%b valid0=%b, expected state0=%b valid0=1",
                 k, channel_state_o[0], channel_valid_o[0], exp_st[k]);
      end
      if (k < 5) gw[0] = wl[k+1];
      tick(1);
      checks++;
      if (width_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL seq_strobe_len_%0d: strobe=%b one cycle later, expected 0", k, width_valid_o);
      end
    end
  endtask

  task automatic test_round_robin;
    int exp_ch[4] = '{0, 1, 3, 0};
    int exp_w[4]  = '{1000, 1850, 1300, 1000};
    int ch, w, cyc;
    enable_i = 1'b0;
    tick(2);
    channel_enable_i = 4'b1011;
    gp   = '{2500, 2500, 2500, 2500};
    gw   = '{1000, 1850, 0, 1300};
    goff = '{0, 800, 0, 1600};
    gen_en = 4'b1011;
    tick(5);
    enable_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(8000, ch, w, cyc);
      checks++;
      if (ch != exp_ch[k] || w != exp_w[k]) begin
        errors++;
        $display("FAIL rr_strobe_%0d: ch=%0d width=%0d, expected ch=%0d width=%0d",
                 k, ch, w, exp_ch[k], exp_w[k]);
      end
    end
    checks++;
    if (channel_state_o !== 4'b0010 || channel_valid_o !== 4'b1011) begin
      errors++;
      $display("FAIL rr_flags: state=%b valid=%b, expected 0010 1011", channel_state_o, channel_valid_o);
    end
  endtask

  task automatic test_timeout;
    int ch, w, cyc;
    gen_en[1] = 1'b0;
    wait_strobe(32000, ch, w, cyc);
    checks++;
    if (ch != 3 || w != 1300) begin
      errors++;
      $display("FAIL timeout_next_strobe: ch=%0d width=%0d, expected ch=3 width=1300", ch, w);
    end
    checks++;
    if (cyc < 25000 || cyc > 28900) begin
      errors++;
      $display("FAIL timeout_duration: %0d cycles between strobes, expected 25000..28900", cyc);
    end
    checks++;
    if (channel_valid_o !== 4'b1001 || channel_state_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flags: valid=%b state1=%b, expected valid=1001 state1=1",
               channel_valid_o, channel_state_o[1]);
    end
  endtask

  task automatic test_abort;
    int ch, w, cyc, hcnt;
    bit dropped, strobe_seen;
    enable_i = 1'b0;
    tick(2);
    channel_enable_i = 4'b0100;
    gen_en = 4'b0100;
    gp[2] = 3000; goff[2] = 0; gw[2] = 1900;
    tick(5);
    enable_i = 1'b1;
    wait_strobe(8000, ch, w, cyc);
    checks++;
    if (ch != 2 || w != 1900 || channel_state_o[2] !== 1'b1 || channel_valid_o !== 4'b0100) begin
      errors++;
      $display("FAIL abort_setup: ch=%0d width=%0d state2=%b valid=%b, expected 2 1900 1 0100",
               ch, w, channel_state_o[2], channel_valid_o);
    end
    gw[2] = 2500;
    hcnt = 0; dropped = 1'b0; strobe_seen = 1'b0;
    for (int i = 0; i < 8000 && !dropped; i++) begin
      tick(1);
      if (pwm_i[2]) hcnt++;
      if (width_valid_o) strobe_seen = 1'b1;
      if (!channel_valid_o[2]) dropped = 1'b1;
    end
    checks++;
    if (!dropped || strobe_seen) begin
      errors++;
      $display("FAIL abort_drop: valid2_cleared=%b strobe_seen=%b, expected 1 0", dropped, strobe_seen);
    end
    checks++;
    if (hcnt < 2003 || hcnt > 2007 || pwm_i[2] !== 1'b1) begin
      errors++;
      $display("FAIL abort_timing: cleared after %0d high cycles pwm2=%b, expected 2003..2007 pwm2=1",
               hcnt, pwm_i[2]);
    end
    checks++;
    if (channel_state_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL abort_state_hold: state2=%b, expected 1", channel_state_o[2]);
    end
    gw[2] = 2000;
    wait_strobe(8000, ch, w, cyc);
    checks++;
    if (ch != 2 || w != 2000 || channel_valid_o[2] !== 1'b1 || channel_state_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL max_width: ch=%0d width=%0d valid2=%b state2=%b, expected 2 2000 1 1",
               ch, w, channel_valid_o[2], channel_state_o[2]);
    end
  endtask

  task automatic test_enable_drop;
    int ch, w, cyc;
    bit ok, lo_ok, strobe_seen;
    logic [3:0] v_save, s_save;
    enable_i = 1'b0;
    tick(2);
    channel_enable_i = 4'b0011;
    gen_en = 4'b0011;
    gp[0] = 3000; gp[1] = 3000; goff[0] = 0; goff[1] = 1500;
    gw[0] = 1500; gw[1] = 1850;
    tick(5);
    enable_i = 1'b1;
    wait_strobe(8000, ch, w, cyc);
    checks++;
    if (ch != 0 || w != 1500) begin
      errors++;
      $display("FAIL drop_setup: ch=%0d width=%0d, expected ch=0 width=1500", ch, w);
    end
    wait_level(1, 1'b0, lo_ok);
    wait_level(1, 1'b1, ok);
    strobe_seen = 1'b0;
    for (int i = 0; i < 702; i++) begin
      tick(1);
      if (width_valid_o) strobe_seen = 1'b1;
    end
    checks++;
    if (!(ok && lo_ok) || busy_o !== 1'b1 || strobe_seen) begin
      errors++;
      $display("FAIL drop_pre: edge_found=%b busy=%b strobe_seen=%b, expected 1 1 0",
               ok && lo_ok, busy_o, strobe_seen);
    end
    v_save = channel_valid_o;
    s_save = channel_state_o;
    enable_i = 1'b0;
    tick(1);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy: busy=%b, expected 0", busy_o);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (width_valid_o) strobe_seen = 1'b1;
    end
    checks++;
    if (strobe_seen || channel_valid_o !== v_save || channel_state_o !== s_save) begin
      errors++;
      $display("FAIL drop_hold: strobe_seen=%b valid=%b state=%b, expected 0 %b %b",
               strobe_seen, channel_valid_o, channel_state_o, v_save, s_save);
    end
    enable_i = 1'b1;
    wait_strobe(8000, ch, w, cyc);
    checks++;
    if (ch != 0 || w != 1500) begin
      errors++;
      $display("FAIL drop_restart: ch=%0d width=%0d, expected ch=0 width=1500", ch, w);
    end
  endtask

  task automatic test_reset_mid_measure;
    bit ok, lo_ok;
    wait_level(1, 1'b0, lo_ok);
    wait_level(1, 1'b1, ok);
    tick(100);
    checks++;
    if (!(ok && lo_ok) || busy_o !== 1'b1 || channel_valid_o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pre: edge_found=%b busy=%b valid=%b, expected 1 1 0001",
               ok && lo_ok, busy_o, channel_valid_o);
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if (channel_state_o !== 4'b0000 || channel_valid_o !== 4'b0000 || width_o !== 11'd0 ||
        width_channel_o !== 2'd0 || width_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: state=%b valid=%b width=%0d ch=%0d strobe=%b busy=%b, expected all 0",
               channel_state_o, channel_valid_o, width_o, width_channel_o, width_valid_o, busy_o);
    end
    tick(2);
    reset_i = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_round_robin;
    test_timeout;
    test_abort;
    test_enable_drop;
    test_reset_mid_measure;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
